// File: rtl/aes_decipher_block.sv
// -----------------------------------------------------------------------------
// aes_decipher_block
//
// Iterative AES inverse cipher datapath. One 128-bit ciphertext block is
// turned into its plaintext, one round every 5 cycles. Each round uses four
// single-word InvSubBytes cycles through a shared external 32-bit inverse
// S-box, then one cycle that combines AddRoundKey, InvMixColumns and the
// InvShiftRows of the following round.
//
// Byte order follows FIPS-197: byte 0 is [127:120]. Word 0 ([127:96]) is
// column 0 and word 3 ([31:0]) is column 3.
//
// Parameters:
//   NUM_ROUNDS   number of AES rounds: 10, 12 or 14 (AES-128/192/256)
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous reset, active-high
//   next_i       start request, accepted only while idle
//   round_o      current round index, selects round_key_i in the key memory
//   round_key_i  round key for round_o, valid in the same cycle
//   inv_sbox_o   word sent to the external inverse S-box, 0 outside SBOX
//   inv_sbox_i   byte-wise InvSubBytes of inv_sbox_o, combinational
//   block_i      ciphertext, sampled only in the INIT cycle
//   new_block_o  working state / plaintext result
//   ready_o      1 = idle and new_block_o holds a valid result
//
// Optional build macro:
//   AES_DEC_OUTPUT_MASK_EN  when defined, new_block_o reads as 128'h0 while
//                           ready_o is low, so intermediate round state is
//                           never visible outside the block. Datapath and
//                           timing are identical in both builds.
// -----------------------------------------------------------------------------
module aes_decipher_block #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         next_i,
    output logic [3:0]   round_o,
    input  logic [127:0] round_key_i,
    output logic [31:0]  inv_sbox_o,
    input  logic [31:0]  inv_sbox_i,
    input  logic [127:0] block_i,
    output logic [127:0] new_block_o,
    output logic         ready_o
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } state_t;

    state_t         state_r;
    logic [3:0]     round_r;
    logic [1:0]     word_r;
    logic [127:0]   block_r;
    logic [31:0]    sbox_word_r;
    logic           ready_r;

    logic [127:0]   init_block_s;
    logic [127:0]   ark_block_s;
    logic [127:0]   round_block_s;
    logic [127:0]   sbox_block_s;
    logic [31:0]    next_sbox_word_s;

    // -------------------------------------------------------------------------
    // GF(2^8) helpers (AES polynomial x^8 + x^4 + x^3 + x + 1)
    // -------------------------------------------------------------------------
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvMixColumns on one column; coefficients 0e/0b/0d/09 are built from
    // the x2/x4/x8 doubling chain so only xtime and XOR gates are needed.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a   [4];
        logic [7:0] m9  [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31 - 8*i -: 8];
            x2     = gf_xtime(a[i]);
            x4     = gf_xtime(x2);
            x8     = gf_xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            r[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
        end
        return r;
    endfunction

    // Row r is rotated right by r columns: out[row][c] = in[row][(c - row) mod 4].
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8*(4*c + row) -: 8] =
                    s[127 - 8*(4*((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Combinational datapath
    // -------------------------------------------------------------------------

    // Round-level transforms: the initial AddRoundKey of the last round key
    // and the combined AddRoundKey/InvMixColumns/InvShiftRows round update.
    always_comb begin
        init_block_s  = inv_shift_rows(block_i ^ round_key_i);
        ark_block_s   = block_r ^ round_key_i;
        round_block_s = inv_shift_rows(inv_mix_columns(ark_block_s));
    end

    // Substitute the S-box result into the word currently being processed.
    always_comb begin
        sbox_block_s = block_r;
        case (word_r)
            2'd0:    sbox_block_s[127:96] = inv_sbox_i;
            2'd1:    sbox_block_s[95:64]  = inv_sbox_i;
            2'd2:    sbox_block_s[63:32]  = inv_sbox_i;
            2'd3:    sbox_block_s[31:0]   = inv_sbox_i;
            default: sbox_block_s         = block_r;
        endcase
    end

    // The word presented to the S-box next cycle. Word w+1 is not touched by
    // the current write, so it can be taken from the register as it stands;
    // after word 3 the S-box port goes quiet for the MAIN cycle.
    always_comb begin
        next_sbox_word_s = 32'h0;
        case (word_r)
            2'd0:    next_sbox_word_s = block_r[95:64];
            2'd1:    next_sbox_word_s = block_r[63:32];
            2'd2:    next_sbox_word_s = block_r[31:0];
            2'd3:    next_sbox_word_s = 32'h0;
            default: next_sbox_word_s = 32'h0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM and working registers
    // -------------------------------------------------------------------------

    // Sequencer: IDLE -> INIT -> (SBOX x4 -> MAIN) x NUM_ROUNDS -> IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            round_r     <= 4'd0;
            word_r      <= 2'd0;
            block_r     <= 128'h0;
            sbox_word_r <= 32'h0;
            ready_r     <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (next_i) begin
                        round_r <= LAST_ROUND;
                        ready_r <= 1'b0;
                        state_r <= INIT;
                    end
                end

                INIT: begin
                    block_r     <= init_block_s;
                    round_r     <= LAST_ROUND - 4'd1;
                    word_r      <= 2'd0;
                    // Preload word 0 of the freshly computed state so the
                    // S-box port is registered and valid on SBOX entry.
                    sbox_word_r <= init_block_s[127:96];
                    state_r     <= SBOX;
                end

                SBOX: begin
                    block_r     <= sbox_block_s;
                    word_r      <= word_r + 2'd1;
                    sbox_word_r <= next_sbox_word_s;
                    if (word_r == 2'd3) begin
                        state_r <= MAIN;
                    end
                end

                MAIN: begin
                    if (round_r != 4'd0) begin
                        block_r     <= round_block_s;
                        round_r     <= round_r - 4'd1;
                        word_r      <= 2'd0;
                        sbox_word_r <= round_block_s[127:96];
                        state_r     <= SBOX;
                    end else begin
                        // Final AddRoundKey: no InvMixColumns in the last round.
                        block_r     <= ark_block_s;
                        ready_r     <= 1'b1;
                        state_r     <= IDLE;
                    end
                end

                default: begin
                    state_r     <= IDLE;
                    round_r     <= 4'd0;
                    word_r      <= 2'd0;
                    sbox_word_r <= 32'h0;
                    ready_r     <= 1'b1;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign round_o    = round_r;
    assign inv_sbox_o = sbox_word_r;
    assign ready_o    = ready_r;

`ifdef AES_DEC_OUTPUT_MASK_EN
    // Only a finished result is allowed out of the block.
    assign new_block_o = ready_r ? block_r : 128'h0;
`else
    assign new_block_o = block_r;
`endif

endmodule

// File: tb/tb_aes_decipher_block.sv
// -----------------------------------------------------------------------------
// tb_aes_decipher_block
//
// Self-checking bench for aes_decipher_block. Two instances are used: AES-128
// (NUM_ROUNDS=10) and AES-256 (NUM_ROUNDS=14). The bench supplies its own
// inverse S-box (derived from GF(2^8) inversion plus the affine map) and a
// key-schedule model answering round_o combinationally. Known FIPS-197
// vectors plus forward-cipher generated pairs are held in a vector table.
// -----------------------------------------------------------------------------
module tb_aes_decipher_block;

    logic         clk = 1'b0;
    logic         rst;
    logic         next_a;
    logic         next_b;
    logic [127:0] blk_in;

    logic [3:0]   round_a, round_b;
    logic [127:0] key_a, key_b;
    logic [31:0]  sbo_a, sbo_b, sbi_a, sbi_b;
    logic [127:0] nb_a, nb_b;
    logic         ready_a, ready_b;

    logic [7:0]   sb  [256];
    logic [7:0]   isb [256];
    logic [127:0] rk_a [16];
    logic [127:0] rk_b [16];

    int           checks;
    int           errors;
    bit           mid_nonzero;

    always #5 clk = ~clk;

    assign key_a = rk_a[round_a];
    assign key_b = rk_b[round_b];
    assign sbi_a = {isb[sbo_a[31:24]], isb[sbo_a[23:16]], isb[sbo_a[15:8]], isb[sbo_a[7:0]]};
    assign sbi_b = {isb[sbo_b[31:24]], isb[sbo_b[23:16]], isb[sbo_b[15:8]], isb[sbo_b[7:0]]};

    aes_decipher_block #(.NUM_ROUNDS(10)) dut_a (
        .clk_i(clk), .rst_i(rst), .next_i(next_a), .round_o(round_a),
        .round_key_i(key_a), .inv_sbox_o(sbo_a), .inv_sbox_i(sbi_a),
        .block_i(blk_in), .new_block_o(nb_a), .ready_o(ready_a));

    aes_decipher_block #(.NUM_ROUNDS(14)) dut_b (
        .clk_i(clk), .rst_i(rst), .next_i(next_b), .round_o(round_b),
        .round_key_i(key_b), .inv_sbox_o(sbo_b), .inv_sbox_i(sbi_b),
        .block_i(blk_in), .new_block_o(nb_b), .ready_o(ready_b));

    // ---------------------------------------------------------------- models
    function automatic logic [7:0] xt(input logic [7:0] b);
        return b[7] ? ({b[6:0], 1'b0} ^ 8'h1b) : {b[6:0], 1'b0};
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    // key is left-aligned: 128-bit keys occupy [255:128]
    task automatic expand_key(input int sel, input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (sel != 0) rk_b[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
            else          rk_a[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
        end
    endtask

    // Forward AES-128 with the schedule currently loaded in rk_a.
    function automatic logic [127:0] encrypt128(input logic [127:0] pt);
        logic [127:0] s, t;
        logic [7:0]   a0, a1, a2, a3;
        s = pt ^ rk_a[0];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[127 - 8*i -: 8] = sb[s[127 - 8*i -: 8]];
            t = s;
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[127 - 8*(4*c + row) -: 8] = t[127 - 8*(4*((c + row) % 4) + row) -: 8];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[127 - 32*c -: 8];
                    a1 = s[119 - 32*c -: 8];
                    a2 = s[111 - 32*c -: 8];
                    a3 = s[103 - 32*c -: 8];
                    s[127 - 32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                           a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                           a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                           xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
            end
            s = s ^ rk_a[r];
        end
        return s;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // --------------------------------------------------------------- helpers
    function automatic logic get_ready(input int sel);
        return (sel != 0) ? ready_b : ready_a;
    endfunction
    function automatic logic [127:0] get_nb(input int sel);
        return (sel != 0) ? nb_b : nb_a;
    endfunction
    function automatic logic [3:0] get_round(input int sel);
        return (sel != 0) ? round_b : round_a;
    endfunction
    function automatic logic [31:0] get_sbo(input int sel);
        return (sel != 0) ? sbo_b : sbo_a;
    endfunction
    task automatic set_next(input int sel, input logic v);
        if (sel != 0) next_b = v;
        else          next_a = v;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset(input int sel, input string name);
        chk({name, "_ready"}, 128'(get_ready(sel)), 128'h1);
        chk({name, "_block"}, get_nb(sel), 128'h0);
        chk({name, "_round"}, 128'(get_round(sel)), 128'h0);
        chk({name, "_sbox"},  128'(get_sbo(sel)), 128'h0);
    endtask

    // Called at the negedge of the INIT cycle (busy cycle 0). Follows the run
    // until ready rises (bounded), checking round_o / inv_sbox_o each cycle.
    task automatic wait_done(input int sel, input int nr, input bit glitch,
                             input string name, output int cycles);
        int k, bad, first_k, exp_round, ph;
        bit in_sbox;
        logic [127:0] nb;
        logic [31:0]  exp_sbo;
        k = 0; bad = 0; first_k = -1;
        while (get_ready(sel) == 1'b0 && k < 200) begin
            nb        = get_nb(sel);
            ph        = (k == 0) ? 4 : (k - 1) % 5;
            in_sbox   = (k > 0) && (ph < 4);
            exp_round = (k == 0) ? nr : nr - 1 - (k - 1) / 5;
`ifdef AES_DEC_OUTPUT_MASK_EN
            exp_sbo = 32'h0;
            if (nb != 128'h0 || (!in_sbox && get_sbo(sel) != exp_sbo) ||
                get_round(sel) != 4'(exp_round)) begin
                bad++;
                if (first_k < 0) first_k = k;
            end
`else
            exp_sbo = in_sbox ? nb[127 - 32*ph -: 32] : 32'h0;
            if (nb != 128'h0) mid_nonzero = 1'b1;
            if (get_sbo(sel) != exp_sbo || get_round(sel) != 4'(exp_round)) begin
                bad++;
                if (first_k < 0) first_k = k;
            end
`endif
            if (k == 1) blk_in = rand128();
            if (glitch && (k == 3 || k == 40)) begin
                set_next(sel, 1'b1);
                blk_in = rand128();
            end
            if (glitch && (k == 4 || k == 41)) set_next(sel, 1'b0);
            @(negedge clk);
            k++;
        end
        cycles = k;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_trace: %0d bad samples, first at busy cycle %0d, required 0",
                     name, bad, first_k);
        end
    endtask

    task automatic run_vec(input int sel, input int nr, input logic [127:0] ct,
                           input logic [127:0] pt, input bit glitch, input string name);
        int cyc;
        blk_in = ct;
        set_next(sel, 1'b1);
        @(negedge clk);
        set_next(sel, 1'b0);
        chk({name, "_ready_fall"}, 128'(get_ready(sel)), 128'h0);
        wait_done(sel, nr, glitch, name, cyc);
        chk({name, "_latency"},   128'(cyc), 128'(1 + 5*nr));
        chk({name, "_plaintext"}, get_nb(sel), pt);
        chk({name, "_idle_sbox"}, 128'(get_sbo(sel)), 128'h0);
    endtask

    // ------------------------------------------------------------- vectors
    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

    vec_t vecs [8];

    initial begin
        int cyc;
        rst = 1'b1; next_a = 1'b0; next_b = 1'b0; blk_in = 128'h0;
        checks = 0; errors = 0; mid_nonzero = 1'b0;
        for (int r = 0; r < 16; r++) begin
            rk_a[r] = 128'h0;
            rk_b[r] = 128'h0;
        end
        build_sbox();

        // Reset, with next_i asserted alongside: reset must win.
        @(negedge clk);
        next_a = 1'b1; next_b = 1'b1;
        @(negedge clk);
        chk_reset(0, "rst_a");
        chk_reset(1, "rst_b");
        rst = 1'b0; next_a = 1'b0; next_b = 1'b0;
        @(negedge clk);
        chk("idle_hold", 128'(ready_a), 128'h1);

        // Vector table: FIPS-197 C.1, Appendix B, then forward-cipher pairs.
        vecs[0] = '{key: C1_KEY, ct: C1_CT, pt: C1_PT};
        vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    ct:  128'h3925841d02dc09fbdc118597196a0b32,
                    pt:  128'h3243f6a8885a308d313198a2e0370734};
        for (int i = 2; i < 8; i++) begin
            vecs[i].key = rand128();
            vecs[i].pt  = rand128();
            expand_key(0, {vecs[i].key, 128'h0}, 4, 10);
            vecs[i].ct  = encrypt128(vecs[i].pt);
        end

        for (int i = 0; i < 8; i++) begin
            expand_key(0, {vecs[i].key, 128'h0}, 4, 10);
            mid_nonzero = 1'b0;
            run_vec(0, 10, vecs[i].ct, vecs[i].pt, 1'b0, $sformatf("vec%0d", i));
`ifndef AES_DEC_OUTPUT_MASK_EN
            if (i == 0) chk("c1_mid_nonzero", 128'(mid_nonzero), 128'h1);
`endif
        end

        // AES-256, FIPS-197 C.3, with full round_o trace.
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        run_vec(1, 14, 128'h8ea2b7ca516745bfeafc49904b496089, C1_PT, 1'b0, "aes256");

        // Busy-ignore: next_i re-pulsed at busy cycles 3 and 40 with other data.
        expand_key(0, {C1_KEY, 128'h0}, 4, 10);
        run_vec(0, 10, C1_CT, C1_PT, 1'b1, "busy");
        @(negedge clk);
        chk("busy_no_queue", 128'(ready_a), 128'h1);

        // Reset mid-operation, then a clean run.
        blk_in = C1_CT;
        next_a = 1'b1;
        @(negedge clk);
        next_a = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset(0, "midrst");
        run_vec(0, 10, C1_CT, C1_PT, 1'b0, "after_rst");

        // Back-to-back with next_i held high.
        blk_in = C1_CT;
        next_a = 1'b1;
        @(negedge clk);
        wait_done(0, 10, 1'b0, "b2b_first", cyc);
        chk("b2b_first_latency", 128'(cyc), 128'd51);
        chk("b2b_first_pt", nb_a, C1_PT);
        blk_in = C1_CT;
        @(negedge clk);
        chk("b2b_restart", 128'(ready_a), 128'h0);
        next_a = 1'b0;
        wait_done(0, 10, 1'b0, "b2b_second", cyc);
        chk("b2b_second_latency", 128'(cyc), 128'd51);
        chk("b2b_second_pt", nb_a, C1_PT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_decipher_block.md
Name: aes_decipher_block

Overview:
Iterative AES inverse cipher datapath. It takes one 128-bit ciphertext block and produces the matching plaintext.
- Processes one round per 5 cycles: 4 single-word InvSubBytes cycles, then one combined round-update cycle.
- Sits in the AES core next to the encipher block and the key memory.
- Drives round_o so the key memory returns round_key_i combinationally in the same cycle.
- Shares an external 32-bit inverse S-box through inv_sbox_o / inv_sbox_i.

Parameters:
NUM_ROUNDS, 10, number of AES rounds; legal values 10, 12, 14 (AES-128/192/256).

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous reset, active-high
next_i  input  1  start request; accepted only in IDLE
round_o  output  4  current round index; selects round_key_i
round_key_i  input  128  round key for round_o, valid same cycle
inv_sbox_o  output  32  word sent to external inverse S-box; 0 outside SBOX state
inv_sbox_i  input  32  byte-wise InvSubBytes of inv_sbox_o, combinational
block_i  input  128  ciphertext; sampled only in INIT cycle
new_block_o  output  128  working state / plaintext result
ready_o  output  1  1 = idle, result valid

Behaviour:
- Reset values: round_o=0, new_block_o=0, ready_o=1, inv_sbox_o=0. Internal state: FSM=IDLE, word counter=0.
- Reset mid-operation aborts immediately. Outputs return to reset values on the next edge; no partial result is retained.
- Byte order follows FIPS-197: byte0=[127:120]. Word0=[127:96] is column 0, word3=[31:0] is column 3.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - next_i=1: round counter <= NUM_ROUNDS, ready <= 0, go to INIT.
  - next_i=0: hold all state.
- INIT (round_o=NUM_ROUNDS):
  - block <= InvShiftRows(block_i ^ round_key_i).
  - round counter <= NUM_ROUNDS-1, word counter <= 0, go to SBOX.
- SBOX (4 cycles, word counter w = 0..3):
  - inv_sbox_o = block word w; block word w <= inv_sbox_i; other words hold.
  - w increments each cycle. After w=3, go to MAIN; w wraps to 0.
- MAIN (round_o = r):
  - r>0: block <= InvShiftRows(InvMixColumns(block ^ round_key_i)); r <= r-1; word counter <= 0; go to SBOX.
  - r=0: block <= block ^ round_key_i (final AddRoundKey, no InvMixColumns); ready <= 1; go to IDLE.
- round_o visible sequence: NUM_ROUNDS (INIT), then NUM_ROUNDS-1 down to 0, each held 5 cycles (4 SBOX + 1 MAIN).
- Latency:
  - ready_o falls the edge after next_i is accepted.
  - It stays low for 1 + 5*NUM_ROUNDS cycles: 51 for AES-128, 61 for AES-192, 71 for AES-256.
  - It rises on the edge that writes the final plaintext.
- new_block_o holds the plaintext until the next accepted next_i plus its INIT cycle.
- next_i is ignored while ready_o=0. It is not queued. A level held high restarts on the first IDLE cycle.
- block_i may change freely except during the INIT cycle.
- round_key_i changing outside the cycle its round_o is presented has no effect.
- Same-cycle rst_i and next_i: reset wins.

Optional Feature:
AES_DEC_OUTPUT_MASK_EN
- Defined: new_block_o is forced to 128'h0 whenever ready_o=0, so intermediate round state never leaves the block.
  - After reset, new_block_o=0 and ready_o=1.
  - Internal datapath and timing are unchanged.
- Undefined: new_block_o always reflects the working register, including intermediate state during decryption.

Test Plan:
- AES-128 FIPS-197 C.1: bench key model for key 000102030405060708090a0b0c0d0e0f, indexed by round_o. Pulse next_i with block_i=69c4e0d86a7b0430d8cdb78070b4c55a -> after 51 cycles ready_o=1 and new_block_o=00112233445566778899aabbccddeeff.
- AES-256 (NUM_ROUNDS=14), key 000102...1f, block_i=8ea2b7ca516745bfeafc49904b496089 -> after 71 cycles, plaintext 00112233445566778899aabbccddeeff. round_o trace: 14, then 13..0, each held 5 cycles.
- Busy-ignore: re-pulse next_i at cycles 3 and 40 with a different block_i -> single completion at cycle 51 with the original plaintext. ready_o never toggles mid-run.
- Reset mid-op: assert rst_i at cycle 20 for 1 cycle -> next cycle ready_o=1, new_block_o=0, round_o=0, inv_sbox_o=0. A fresh next_i then decrypts the C.1 vector correctly.
- Round-trip: 200 random key/plaintext pairs through the encipher block, then this block -> original plaintext every time. Back-to-back next_i held high -> next start exactly 1 cycle after ready_o rises.
- With AES_DEC_OUTPUT_MASK_EN defined: new_block_o=0 on every cycle with ready_o=0, and the final value matches the C.1 plaintext. Without it: new_block_o is nonzero mid-run for the C.1 vector.
